task_4_frame_arbiter: RTL and testbench
=======================================

Name: task_4_frame_arbiter

Overview:
Round-robin, frame-granular arbiter that shares a single downstream task-input byte stream (the task input FIFO/loader) between N_SRC valid/ready/last byte sources. Once a source is granted, it owns the link until its tlast beat is accepted, so frames never interleave. The block gates new grants on downstream busy, counts frame length, and truncates/drains over-length frames.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
DATA_W, 8, byte lane width
MAX_FRAME, 256, max beats per forwarded frame (>=2); counter width = clog2(MAX_FRAME+1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_tvalid  in  N_SRC  per-source valid
i_tdata  in  N_SRC*DATA_W  per-source data, source k at [k*DATA_W +: DATA_W]
i_tlast  in  N_SRC  per-source last
o_tready  out  N_SRC  per-source ready
o_tvalid  out  1  downstream valid
o_tdata  out  DATA_W  downstream data
o_tlast  out  1  downstream last (source tlast or forced truncation)
i_ds_ready  in  1  downstream can accept beat
i_ds_busy  in  1  downstream still processing previous frame
o_grant  out  N_SRC  one-hot current owner, 0 when none
o_frame_len  out  clog2(MAX_FRAME+1)  beats of last completed frame
o_frame_done  out  1  1-cycle pulse after a frame's final downstream beat
o_err_overlen  out  1  1-cycle pulse when truncation occurs

Behaviour:
- Reset (i_rst_n=0, async): state IDLE; o_grant=0, o_tready=0, o_tvalid=0, o_tlast=0, o_frame_len=0, o_frame_done=0, o_err_overlen=0; rr pointer last=N_SRC-1 (src0 has top priority first).
- States: IDLE, GRANT, XFER, DRAIN.
- IDLE: request = i_tvalid != 0. If request and !i_ds_busy -> GRANT, registering winner = first set bit searching from (last+1) mod N_SRC upward with wrap. Else stay.
- GRANT: one cycle; o_grant = one-hot winner; beat counter cleared; -> XFER. No beats move in GRANT.
- XFER: combinational pass-through of granted source: o_tvalid=i_tvalid[g], o_tdata=i_tdata[g], o_tready[g]=i_ds_ready, all other o_tready=0. Beat accepted when i_tvalid[g]&i_ds_ready; counter increments.
  - o_tlast = i_tlast[g] OR (count == MAX_FRAME-1).
  - Accepted beat with i_tlast[g]: o_frame_len <= count+1, o_frame_done pulse next cycle, last <= g, -> IDLE, o_grant cleared.
  - Accepted beat with count==MAX_FRAME-1 and !i_tlast[g]: forwarded with forced o_tlast; o_frame_len <= MAX_FRAME; o_frame_done and o_err_overlen pulse next cycle; -> DRAIN.
  - Source dropping tvalid mid-frame: grant held indefinitely (no timeout).
- DRAIN: o_tvalid=0; o_tready[g]=1; beats discarded; on i_tvalid[g]&i_tlast[g]: last <= g, -> IDLE.
- Latency: request seen in IDLE -> first possible beat in XFER 2 cycles later. Back-to-back frames: >=2 idle cycles between frames (IDLE, GRANT).
- i_ds_busy sampled only in IDLE; assertion during XFER is ignored (downstream uses i_ds_ready for backpressure).
- Request withdrawn during GRANT: still enter XFER and wait for the granted source.
- MAX_FRAME-beat frame ending in real tlast on the final beat: normal completion, no error.
- Reset mid-frame: outputs return to reset values immediately; partial frame is abandoned; pointer resets.

Test Plan:
- Single source: src1 sends 5-beat frame 0x10..0x14, ds_ready=1 -> o_tdata 0x10..0x14, o_tlast on 0x14, o_frame_len=5, one o_frame_done pulse, o_grant=4'b0010 during frame.
- Round robin: all 4 sources continuously request 3-beat frames -> grant order 0,1,2,3,0; no interleaved bytes; 2 idle cycles between frames.
- Backpressure: src0 4-beat frame, ds_ready toggled 1,0,0,1,... -> o_tready[0] mirrors ds_ready; all 4 bytes delivered in order, none duplicated; i_ds_busy=1 in IDLE with src2 requesting -> no grant until busy=0.
- Over-length (MAX_FRAME=8): src3 sends 12 beats, tlast on 12th -> 8 beats forwarded, forced o_tlast on 8th, o_err_overlen pulse, o_frame_len=8, beats 9..12 accepted and dropped (o_tvalid=0), then IDLE.
- Exact-length: 8-beat frame with tlast on beat 8 (MAX_FRAME=8) -> no o_err_overlen, o_frame_len=8.
- Async reset: assert i_rst_n=0 mid-frame between clock edges -> o_tready, o_grant, o_tvalid go 0 before next edge; after release src0 wins first.

Source files
------------

// File: rtl/task_4_frame_arbiter.sv
// Frame-granular round-robin arbiter: N_SRC valid/ready/last byte sources share one
// downstream task-input stream; a granted source owns the link until its frame ends.

module task_4_frame_arbiter_lane (
  input  logic sel,
  input  logic xfer,
  input  logic drain,
  input  logic ds_ready,
  output logic ready
);
  // Owner sees downstream ready while forwarding, and unconditional ready while draining.
  assign ready = sel & ((xfer & ds_ready) | drain);
endmodule

module task_4_frame_arbiter #(
  parameter  int N_SRC     = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_FRAME = 256,
  localparam int CNT_W     = $clog2(MAX_FRAME + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_SRC-1:0]        i_tvalid,
  input  logic [N_SRC*DATA_W-1:0] i_tdata,
  input  logic [N_SRC-1:0]        i_tlast,
  output logic [N_SRC-1:0]        o_tready,
  output logic                    o_tvalid,
  output logic [DATA_W-1:0]       o_tdata,
  output logic                    o_tlast,
  input  logic                    i_ds_ready,
  input  logic                    i_ds_busy,
  output logic [N_SRC-1:0]        o_grant,
  output logic [CNT_W-1:0]        o_frame_len,
  output logic                    o_frame_done,
  output logic                    o_err_overlen
);
  localparam int                IDX_W    = $clog2(N_SRC);
  localparam int                LAST_RST = N_SRC - 1;
  localparam int                MAX_M1   = MAX_FRAME - 1;
  localparam logic [IDX_W:0]    NSRC_L   = N_SRC[IDX_W:0];
  localparam logic [IDX_W-1:0]  PTR_RST  = LAST_RST[IDX_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_LIM  = MAX_M1[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  LEN_MAX  = MAX_FRAME[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DRAIN} state_t;

  state_t                         state, state_nxt;
  logic [IDX_W-1:0]               gnt, last, win;
  logic                           win_vld;
  logic [IDX_W:0]                 cand;
  logic [CNT_W-1:0]               count;
  logic [N_SRC-1:0][DATA_W-1:0]   data_arr;
  logic                           sel_vld, sel_last, at_max, accept;
  logic                           in_xfer, in_drain;

  assign data_arr = i_tdata;
  assign sel_vld  = i_tvalid[gnt];
  assign sel_last = i_tlast[gnt];
  assign at_max   = (count == CNT_LIM);
  assign in_xfer  = (state == XFER);
  assign in_drain = (state == DRAIN);
  assign accept   = in_xfer & sel_vld & i_ds_ready;

  // First requester after the previous owner, wrapping around.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = {1'b0, last} + i[IDX_W:0];
      if (cand >= NSRC_L) cand = cand - NSRC_L;
      if (!win_vld && i_tvalid[cand[IDX_W-1:0]]) begin
        win     = cand[IDX_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_vld && !i_ds_busy) state_nxt = GRANT;
      GRANT: state_nxt = XFER;
      XFER:  if (accept) begin
               if (sel_last)    state_nxt = IDLE;
               else if (at_max) state_nxt = DRAIN;
             end
      DRAIN: if (sel_vld && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_grant  = (state != IDLE) ? ({{(N_SRC-1){1'b0}}, 1'b1} << gnt) : '0;
  assign o_tvalid = in_xfer & sel_vld;
  assign o_tdata  = in_xfer ? data_arr[gnt] : '0;
  assign o_tlast  = in_xfer & (sel_last | at_max);

  for (genvar k = 0; k < N_SRC; k++) begin : g_lane
    task_4_frame_arbiter_lane u_lane (
      .sel      (o_grant[k]),
      .xfer     (in_xfer),
      .drain    (in_drain),
      .ds_ready (i_ds_ready),
      .ready    (o_tready[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt           <= '0;
      last          <= PTR_RST;
      count         <= '0;
      o_frame_len   <= '0;
      o_frame_done  <= 1'b0;
      o_err_overlen <= 1'b0;
    end else begin
      o_frame_done  <= 1'b0;
      o_err_overlen <= 1'b0;
      case (state)
        IDLE:  if (state_nxt == GRANT) gnt <= win;
        GRANT: count <= '0;
        XFER:  if (accept) begin
                 count <= count + 1'b1;
                 if (sel_last) begin
                   o_frame_len  <= count + 1'b1;
                   o_frame_done <= 1'b1;
                   last         <= gnt;
                 end else if (at_max) begin
                   // Truncated: the rest of the source frame is swallowed in DRAIN.
                   o_frame_len   <= LEN_MAX;
                   o_frame_done  <= 1'b1;
                   o_err_overlen <= 1'b1;
                 end
               end
        DRAIN: if (sel_vld && sel_last) last <= gnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_task_4_frame_arbiter.sv
// Randomized scoreboard bench for task_4_frame_arbiter (N_SRC=4, MAX_FRAME=8).

module tb_task_4_frame_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MF = 8;
  localparam int CW = $clog2(MF + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    tvalid, tlast, tready, grant;
  logic [N*DW-1:0] tdata;
  logic            ovalid, olast, ds_ready, ds_busy, fdone, ferr;
  logic [DW-1:0]   odata;
  logic [CW-1:0]   flen;

  always #5 clk = ~clk;

  task_4_frame_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_FRAME(MF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tvalid(tvalid), .i_tdata(tdata), .i_tlast(tlast),
    .o_tready(tready), .o_tvalid(ovalid), .o_tdata(odata), .o_tlast(olast),
    .i_ds_ready(ds_ready), .i_ds_busy(ds_busy), .o_grant(grant),
    .o_frame_len(flen), .o_frame_done(fdone), .o_err_overlen(ferr)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [CW-1:0] len; logic err; } fr_t;

  beat_t src_q[N][$];
  beat_t exp_q[N][$];
  fr_t   fr_q[N][$];

  int vectors = 0;
  int fails   = 0;
  bit mon_en  = 1'b0;
  bit drv_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    fails++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] tv, input int lst);
    for (int i = 1; i <= N; i++)
      if (tv[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    if (!$onehot(v)) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Source k gets a list of frames; expected downstream view is the first MF beats,
  // with last on the final forwarded beat, plus the frame length/overlength record.
  task automatic build_frames(input int nfr);
    int len, fwd, seq;
    beat_t b;
    fr_t f;
    for (int k = 0; k < N; k++) begin
      seq = 0;
      for (int fi = 0; fi < nfr; fi++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: len = $urandom_range(1, 7);
          6:                len = MF;
          default:          len = $urandom_range(MF + 1, MF + 4);
        endcase
        fwd = (len > MF) ? MF : len;
        for (int j = 0; j < len; j++) begin
          b.data = DW'(k * 64 + (seq % 64));
          seq++;
          b.last = (j == len - 1);
          src_q[k].push_back(b);
          if (j < fwd) begin
            b.last = (j == fwd - 1);
            exp_q[k].push_back(b);
          end
        end
        f.len = CW'(fwd);
        f.err = (len > MF);
        fr_q[k].push_back(f);
      end
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += src_q[k].size() + exp_q[k].size() + fr_q[k].size();
    return s;
  endfunction

  // Source/downstream driver: inputs change just after the rising edge.
  initial begin
    logic [N-1:0] fire;
    forever begin
      @(negedge clk);
      fire = tvalid & tready;
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int k = 0; k < N; k++) begin
          if (fire[k]) begin
            void'(src_q[k].pop_front());
            tvalid[k] = 1'b0;
          end
          if (!tvalid[k] && src_q[k].size() > 0 && $urandom_range(0, 9) < 6) tvalid[k] = 1'b1;
          if (tvalid[k]) begin
            tdata[k*DW +: DW] = src_q[k][0].data;
            tlast[k]          = src_q[k][0].last;
          end
        end
        ds_ready = ($urandom_range(0, 9) < 7);
        ds_busy  = ($urandom_range(0, 9) < 3);
      end
    end
  end

  // Monitor: arbitration decisions, forwarded beats and frame completions.
  initial begin
    logic [N-1:0] prev_tv, prev_grant;
    logic         prev_busy;
    int           mlast, last_src, p, g;
    beat_t        eb;
    fr_t          ef;
    prev_tv = '0; prev_grant = '0; prev_busy = 1'b0;
    mlast = N - 1; last_src = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_grant == '0 && grant != '0) begin
          p = rr_pick(prev_tv, mlast);
          chk("rr_winner", 32'(grant), (p < 0) ? 32'd0 : (32'd1 << p));
          chk("busy_gate", 32'(prev_busy), 32'd0);
          if (p >= 0) mlast = p;
        end
        if (ovalid && ds_ready) begin
          g = onehot_idx(grant);
          chk("tready_route", 32'(tready), 32'(grant));
          if (g < 0 || exp_q[g].size() == 0) flag("unexpected_beat");
          else begin
            eb = exp_q[g].pop_front();
            chk("beat_data", 32'(odata), 32'(eb.data));
            chk("beat_last", 32'(olast), 32'(eb.last));
            last_src = g;
          end
        end
        if (fdone) begin
          if (fr_q[last_src].size() == 0) flag("unexpected_done");
          else begin
            ef = fr_q[last_src].pop_front();
            chk("frame_len", 32'(flen), 32'(ef.len));
            chk("overlen_flag", 32'(ferr), 32'(ef.err));
          end
        end else if (ferr) flag("overlen_without_done");
      end
      prev_tv = tvalid; prev_grant = grant; prev_busy = ds_busy;
    end
  end

  initial begin
    bit done;
    rst_n = 1'b0; tvalid = '0; tdata = '0; tlast = '0; ds_ready = 1'b0; ds_busy = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_tvalid", 32'(ovalid), 32'd0);
    chk("rst_tlast", 32'(olast), 32'd0);
    chk("rst_frame_len", 32'(flen), 32'd0);
    chk("rst_frame_done", 32'(fdone), 32'd0);
    chk("rst_err", 32'(ferr), 32'd0);

    build_frames(6);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drv_en = 1'b1;

    done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk);
      if (pending() == 0 && grant == '0) done = 1'b1;
    end
    if (!done) flag("random_phase_timeout");
    repeat (3) @(negedge clk);
    chk("leftover_items", 32'(pending()), 32'd0);

    // Directed: busy gating, then asynchronous reset in the middle of a frame.
    drv_en = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    tvalid = 4'b0100; tdata = '0; tdata[2*DW +: DW] = 8'hA5; tlast = '0;
    ds_ready = 1'b1; ds_busy = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_holds_grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    ds_busy = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (grant != '0) done = 1'b1;
    end
    if (!done) flag("grant_after_busy_timeout");
    chk("grant_after_busy", 32'(grant), 32'h4);
    repeat (2) @(negedge clk);
    chk("midframe_tvalid", 32'(ovalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tready", 32'(tready), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_tvalid", 32'(ovalid), 32'd0);
    chk("async_rst_len", 32'(flen), 32'd0);
    tvalid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (grant != '0) done = 1'b1;
    end
    if (!done) flag("post_reset_grant_timeout");
    chk("post_reset_winner", 32'(grant), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
